pc_gen_unit: RTL and testbench

PC_GEN_UNIT -- requirements
Module: pc_gen_unit

---
 rtl/pc_gen_unit.sv | 173 +++++++++++++++++
 tb/tb_pc_gen_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_unit
// Purpose  : Fetch PC generator with BOOT/RUN/HALT FSM, trap/mret redirect
//            and a circular return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_en,
  input  logic [XLEN-1:0] branch_target,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic            trap_en,
  input  logic            mret_en,
  input  logic [XLEN-1:0] mepc,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow,
  output logic [1:0]      state
);

  localparam int c_ptr_w = $clog2(RAS_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(RAS_DEPTH);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t              r_state;
  logic [XLEN-1:0]     r_pc;
  logic                r_pc_valid;
  logic                r_misalign_exc;
  logic [XLEN-1:0]     r_misalign_addr;
  logic                r_ras_empty;
  logic                r_ras_full;
  logic                r_ras_underflow;
  logic [c_ptr_w-1:0]  r_wptr;
  logic [c_cnt_w-1:0]  r_count;
  logic [XLEN-1:0]     r_ras [RAS_DEPTH];

  state_t              w_state_nxt;
  logic [XLEN-1:0]     w_pc_nxt;
  logic [XLEN-1:0]     w_pc_inc;
  logic [XLEN-1:0]     w_ras_top;
  logic                w_push;
  logic                w_pop;
  logic                w_misalign;
  logic                w_underflow;
  logic [c_cnt_w-1:0]  w_count_nxt;

  assign w_pc_inc  = r_pc + XLEN'(4);
  assign w_ras_top = r_ras[r_wptr - c_ptr_w'(1)];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_misalign  = 1'b0;
    w_underflow = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (trap_en) begin
          w_pc_nxt = TRAP_VEC;
        end else if (halt_req) begin
          w_state_nxt = HALT;
        end else if (mret_en) begin
          w_pc_nxt = mepc & ~XLEN'(3);
        end else if (stall) begin
          w_pc_nxt = r_pc;
        end else if (branch_en) begin
          // A misaligned target is turned into a trap and never pushes.
          if (branch_target[1:0] != 2'b00) begin
            w_pc_nxt   = TRAP_VEC;
            w_misalign = 1'b1;
          end else begin
            w_pc_nxt = branch_target;
            w_push   = call_en;
          end
        end else if (ret_en) begin
          if (r_count != '0) begin
            w_pc_nxt = w_ras_top;
            w_pop    = 1'b1;
          end else begin
            w_pc_nxt    = w_pc_inc;
            w_underflow = 1'b1;
          end
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      HALT: begin
        if (trap_en) begin
          w_pc_nxt    = TRAP_VEC;
          w_state_nxt = RUN;
        end else if (resume) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  // Pushing into a full stack overwrites the oldest slot, so the count saturates.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push) begin
      if (r_count != c_full_cnt) w_count_nxt = r_count + c_cnt_w'(1);
    end else if (w_pop) begin
      w_count_nxt = r_count - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= BOOT;
      r_pc            <= RESET_PC;
      r_pc_valid      <= 1'b0;
      r_misalign_exc  <= 1'b0;
      r_misalign_addr <= '0;
      r_ras_underflow <= 1'b0;
      r_ras_empty     <= 1'b1;
      r_ras_full      <= 1'b0;
      r_count         <= '0;
      r_wptr          <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_pc            <= w_pc_nxt;
      r_pc_valid      <= (w_state_nxt == RUN);
      r_misalign_exc  <= w_misalign;
      if (w_misalign) r_misalign_addr <= branch_target;
      r_ras_underflow <= w_underflow;
      r_count         <= w_count_nxt;
      r_ras_empty     <= (w_count_nxt == '0);
      r_ras_full      <= (w_count_nxt == c_full_cnt);
      if (w_push)      r_wptr <= r_wptr + c_ptr_w'(1);
      else if (w_pop)  r_wptr <= r_wptr - c_ptr_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_ras[r_wptr] <= w_pc_inc;
  end

  assign pc            = r_pc;
  assign pc_valid      = r_pc_valid;
  assign misalign_exc  = r_misalign_exc;
  assign misalign_addr = r_misalign_addr;
  assign ras_empty     = r_ras_empty;
  assign ras_full      = r_ras_full;
  assign ras_underflow = r_ras_underflow;
  assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen_unit
// Purpose  : Directed + random checks of pc_gen_unit against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen_unit;

  localparam logic [31:0] c_tv    = 32'h0000_0100;
  localparam int          c_depth = 4;

  logic        clk = 1'b0;
  logic        rst, stall, branch_en, call_en, ret_en, trap_en, mret_en, halt_req, resume;
  logic [31:0] branch_target, mepc;
  logic [31:0] pc, misalign_addr;
  logic        pc_valid, misalign_exc, ras_empty, ras_full, ras_underflow;
  logic [1:0]  state;

  logic        branch_en8;
  logic [7:0]  branch_target8, pc8, misalign_addr8;
  logic        pc_valid8, misalign_exc8, ras_empty8, ras_full8, ras_underflow8;
  logic [1:0]  state8;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state as int, RAS as a queue (back = most recent).
  int          m_state;
  logic [31:0] m_pc, m_maddr;
  logic        m_valid, m_mexc, m_und;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_gen_unit #(.XLEN(32), .RAS_DEPTH(c_depth)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en),
    .branch_target(branch_target), .call_en(call_en), .ret_en(ret_en),
    .trap_en(trap_en), .mret_en(mret_en), .mepc(mepc), .halt_req(halt_req),
    .resume(resume), .pc(pc), .pc_valid(pc_valid), .misalign_exc(misalign_exc),
    .misalign_addr(misalign_addr), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_underflow(ras_underflow), .state(state)
  );

  pc_gen_unit #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .stall(1'b0), .branch_en(branch_en8),
    .branch_target(branch_target8), .call_en(1'b0), .ret_en(1'b0),
    .trap_en(1'b0), .mret_en(1'b0), .mepc(8'h00), .halt_req(1'b0),
    .resume(1'b0), .pc(pc8), .pc_valid(pc_valid8), .misalign_exc(misalign_exc8),
    .misalign_addr(misalign_addr8), .ras_empty(ras_empty8), .ras_full(ras_full8),
    .ras_underflow(ras_underflow8), .state(state8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; branch_en = 0; call_en = 0; ret_en = 0; trap_en = 0;
    mret_en = 0; halt_req = 0; resume = 0; branch_target = 0; mepc = 0;
  endtask

  task automatic model_step();
    m_mexc = 0;
    m_und  = 0;
    if (rst) begin
      m_state = 0; m_pc = 0; m_maddr = 0; m_ras.delete();
    end else begin
      case (m_state)
        0: m_state = 1;
        1: begin
          if (trap_en)       m_pc = c_tv;
          else if (halt_req) m_state = 2;
          else if (mret_en)  m_pc = mepc - (mepc % 4);
          else if (stall)    m_pc = m_pc;
          else if (branch_en) begin
            if (branch_target % 4 != 0) begin
              m_pc = c_tv; m_mexc = 1; m_maddr = branch_target;
            end else begin
              if (call_en) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > c_depth) void'(m_ras.pop_front());
              end
              m_pc = branch_target;
            end
          end else if (ret_en) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = m_pc + 32'd4; m_und = 1; end
          end else m_pc = m_pc + 32'd4;
        end
        default: begin
          if (trap_en) begin m_pc = c_tv; m_state = 1; end
          else if (resume) m_state = 1;
        end
      endcase
    end
    m_valid = (m_state == 1);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("state", {30'd0, state}, m_state);
    chk("pc", pc, m_pc);
    chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
    chk("misalign_exc", {31'd0, misalign_exc}, {31'd0, m_mexc});
    chk("misalign_addr", misalign_addr, m_maddr);
    chk("ras_empty", {31'd0, ras_empty}, (m_ras.size() == 0) ? 32'd1 : 32'd0);
    chk("ras_full", {31'd0, ras_full}, (m_ras.size() == c_depth) ? 32'd1 : 32'd0);
    chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, m_und});
    clear_inputs();
  endtask

  task automatic branch_to(input logic [31:0] tgt, input logic call);
    branch_en = 1; branch_target = tgt; call_en = call;
    step();
  endtask

  initial begin
    rst = 1; branch_en8 = 0; branch_target8 = 0;
    clear_inputs();
    step();
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_empty", {31'd0, ras_empty}, 32'd1);
    rst = 0;
    step();
    chk("boot_to_run_pc", pc, 32'd0);
    chk("boot_valid", {31'd0, pc_valid}, 32'd1);
    step(); chk("seq4", pc, 32'd4);
    step(); chk("seq8", pc, 32'd8);
    step(); chk("seq12", pc, 32'd12);

    // 8-bit instance: wrap from 0xFC to 0x00
    branch_en8 = 1; branch_target8 = 8'hFC;
    step();
    branch_en8 = 0;
    chk("w8_at_fc", {24'd0, pc8}, 32'hFC);
    step();
    chk("w8_wrap", {24'd0, pc8}, 32'h00);

    // Priority: trap beats mret/branch/stall
    branch_to(32'h40, 0);
    trap_en = 1; mret_en = 1; mepc = 32'h203; branch_en = 1; branch_target = 32'h80; stall = 1;
    step(); chk("prio_trap", pc, 32'h100);
    mret_en = 1; mepc = 32'h203;
    step(); chk("prio_mret", pc, 32'h200);

    // RAS fill past depth, drain, underflow
    branch_to(32'h10, 0);
    for (int k = 2; k <= 6; k++) branch_to(32'(k * 16), 1);
    chk("ras_full_after5", {31'd0, ras_full}, 32'd1);
    ret_en = 1; step(); chk("ret1", pc, 32'h54);
    ret_en = 1; step(); chk("ret2", pc, 32'h44);
    ret_en = 1; step(); chk("ret3", pc, 32'h34);
    ret_en = 1; step(); chk("ret4", pc, 32'h24);
    chk("ras_drained", {31'd0, ras_empty}, 32'd1);
    ret_en = 1; step(); chk("ret_under_pc", pc, 32'h28);
    chk("ret_under_flag", {31'd0, ras_underflow}, 32'd1);

    // Misaligned call: trap, no push
    branch_to(32'h102, 1);
    chk("mis_pc", pc, 32'h100);
    chk("mis_addr", misalign_addr, 32'h102);
    chk("mis_no_push", {31'd0, ras_empty}, 32'd1);
    step(); chk("mis_pulse_end", {31'd0, misalign_exc}, 32'd0);

    // Halt / resume / trap out of halt
    branch_to(32'h20, 0);
    halt_req = 1; step(); chk("halt_state", {30'd0, state}, 32'd2);
    branch_to(32'h300, 0); chk("halt_hold_pc", pc, 32'h20);
    resume = 1; step(); chk("resume_pc", pc, 32'h20);
    halt_req = 1; step();
    trap_en = 1; step(); chk("halt_trap_pc", pc, 32'h100);
    branch_to(32'h80, 1);
    halt_req = 1; step();
    rst = 1; trap_en = 1; step(); rst = 0;
    chk("rst_in_halt_state", {30'd0, state}, 32'd0);
    chk("rst_in_halt_pc", pc, 32'd0);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      trap_en   = ($urandom_range(0, 19) == 0);
      mret_en   = ($urandom_range(0, 19) == 0);
      halt_req  = ($urandom_range(0, 24) == 0);
      resume    = ($urandom_range(0, 2) == 0);
      stall     = ($urandom_range(0, 5) == 0);
      branch_en = ($urandom_range(0, 2) == 0);
      call_en   = ($urandom_range(0, 1) == 0);
      ret_en    = ($urandom_range(0, 2) == 0);
      mepc      = $urandom;
      branch_target = $urandom;
      if ($urandom_range(0, 7) != 0) branch_target[1:0] = 2'b00;
      step();
      rst = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
